// File: rtl/seq_divider_if.sv
// Start/busy/done handshake bundle for seq_divider; the dz_err signal exists only
// when DIV_ZERO_ERR_EN is defined.
interface seq_divider_if #(
    parameter int N = 8
);
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
`ifdef DIV_ZERO_ERR_EN
    logic           dz_err;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dz_err
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dz_err
    );
`else
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder
    );
`endif
endinterface

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per clock. Define DIV_ZERO_ERR_EN for the one-cycle divide-by-zero path and dz_err.
module seq_divider #(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(2*N+1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [2*N-1:0] dvd;
    logic [2*N-1:0] q;
    logic [N-1:0]   dsr;
    logic [N-1:0]   r;
    logic [CW-1:0]  count;
`ifdef DIV_ZERO_ERR_EN
    logic           dz_pend;
`endif

    logic [N:0]     r_shift;
    logic [N-1:0]   r_next;
    logic           qbit;
    logic [2*N-1:0] q_next;

    // The stored partial remainder is always below the divisor, so only the shifted
    // value needs the extra bit; the difference after subtraction fits in N bits.
    always_comb begin
        r_shift = {r, dvd[2*N-1]};
        qbit    = (r_shift >= {1'b0, dsr});
        r_next  = qbit ? (r_shift[N-1:0] - dsr) : r_shift[N-1:0];
        q_next  = {q[2*N-2:0], qbit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            dvd           <= '0;
            q             <= '0;
            dsr           <= '0;
            r             <= '0;
            count         <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
`ifdef DIV_ZERO_ERR_EN
            dz_pend       <= 1'b0;
            bus.dz_err    <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (bus.start) begin
                        state    <= RUN;
                        bus.busy <= 1'b1;
                        dvd      <= bus.dividend;
                        dsr      <= bus.divisor;
                        r        <= '0;
                        q        <= '0;
                        count    <= CW'(2*N);
`ifdef DIV_ZERO_ERR_EN
                        dz_pend  <= (bus.divisor == '0);
`endif
                    end
                end
                RUN: begin
`ifdef DIV_ZERO_ERR_EN
                    if (dz_pend) begin
                        state         <= DONE;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.quotient  <= '1;
                        bus.remainder <= dvd[N-1:0];
                        bus.dz_err    <= 1'b1;
                        dz_pend       <= 1'b0;
                    end else
`endif
                    begin
                        dvd   <= dvd << 1;
                        r     <= r_next;
                        q     <= q_next;
                        count <= count - CW'(1);
                        if (count == CW'(1)) begin
                            state         <= DONE;
                            bus.busy      <= 1'b0;
                            bus.done      <= 1'b1;
                            bus.quotient  <= q_next;
                            bus.remainder <= r_next;
`ifdef DIV_ZERO_ERR_EN
                            bus.dz_err    <= 1'b0;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
